hs4_rx: RTL and testbench



---
 rtl/hs4_pkg.sv | 13 +
 rtl/hs4_rx_sync_chain.sv | 24 ++
 rtl/hs4_rx.sv | 90 +++++++++
 tb/tb_hs4_rx.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs4_pkg.sv
// Shared types and constants for the 4-phase bundled-data handshake blocks.
package hs4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } hs4_state_t;

    localparam int unsigned HS4_SYNC_MIN = 2;
    localparam int unsigned HS4_SYNC_MAX = 4;

endpackage : hs4_pkg

// File: rtl/hs4_rx_sync_chain.sv
// Single-bit flop synchronizer chain, async active-low reset to 0.
// Shared between the 4-phase receiver (req) and transmitter (ack).
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_chain

// File: rtl/hs4_rx.sv
// Responder end of a 4-phase bundled-data req/ack handshake across clock domains.
// Define HS4_RX_ERR_EN to add the sticky protocol-error output err_o.
module hs4_rx
    import hs4_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready
`ifdef HS4_RX_ERR_EN
    ,
    output logic              err_o
`endif
);

    generate
        if (SYNC_STAGES < HS4_SYNC_MIN || SYNC_STAGES > HS4_SYNC_MAX) begin : g_bad_stages
            $error("hs4_rx: SYNC_STAGES out of range");
        end
    endgenerate

    logic       req_sync;
    hs4_state_t state_q;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (req_in),
        .q       (req_sync)
    );

    // Capture on synchronized req, hand off to consumer, then ack and wait for req to drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ack_out  <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_sync) begin
                        rx_data  <= data_in;
                        rx_valid <= 1'b1;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (rx_ready) begin
                        rx_valid <= 1'b0;
                        ack_out  <= 1'b1;
                        state_q  <= ACK;
                    end
                end
                ACK: begin
                    if (!req_sync) begin
                        ack_out <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ack_out  <= 1'b0;
                    rx_valid <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

`ifdef HS4_RX_ERR_EN
    // Request withdrawn before it was acknowledged; sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_o <= 1'b0;
        end else if (state_q == HOLD && !req_sync) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule : hs4_rx

// File: tb/tb_hs4_rx.sv
// Directed self-checking bench for hs4_rx (DATA_W=8, SYNC_STAGES=2).
module tb_hs4_rx;

    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              reset_n;
    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
`ifdef HS4_RX_ERR_EN
    logic              err_o;
`endif

    int checks = 0;
    int errors = 0;

    hs4_rx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_in   (req_in),
        .data_in  (data_in),
        .ack_out  (ack_out),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
`ifdef HS4_RX_ERR_EN
        ,
        .err_o    (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one active edge; sample point is 1 time unit after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle;
        req_in   = 1'b0;
        rx_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        req_in   = 1'b0;
        data_in  = '0;
        rx_ready = 1'b0;
        #1;
        checks++;
        if ({ack_out, rx_valid, rx_data} !== 10'h000) begin
            errors++;
            $display("FAIL reset_init: got ack/valid/data=%b/%b/%h want 0/0/00", ack_out, rx_valid, rx_data);
        end
        req_in = 1'b1;
        repeat (3) tick();
        checks++;
        if ({ack_out, rx_valid, rx_data} !== 10'h000) begin
            errors++;
            $display("FAIL reset_held_req: got ack/valid/data=%b/%b/%h want 0/0/00", ack_out, rx_valid, rx_data);
        end
        req_in  = 1'b0;
        reset_n = 1'b1;
        repeat (4) tick();
        checks++;
        if ({ack_out, rx_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle: got ack/valid=%b/%b want 0/0", ack_out, rx_valid);
        end
    endtask

    task automatic test_single;
        data_in  = 8'hA5;
        rx_ready = 1'b1;
        req_in   = 1'b1;
        tick();  // edge k
        tick();  // edge k+1
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid: got %b want 0 after k+1", rx_valid);
        end
        tick();  // edge k+2
        checks++;
        if ({ack_out, rx_valid, rx_data} !== {1'b0, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL single_capture: got ack/valid/data=%b/%b/%h want 0/1/a5", ack_out, rx_valid, rx_data);
        end
        tick();  // edge k+3
        checks++;
        if ({ack_out, rx_valid, rx_data} !== {1'b1, 1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL single_ack_rise: got ack/valid/data=%b/%b/%h want 1/0/a5", ack_out, rx_valid, rx_data);
        end
        repeat (3) tick();
        req_in = 1'b0;
        tick();  // edge m
        tick();  // edge m+1
        checks++;
        if (ack_out !== 1'b1) begin
            errors++;
            $display("FAIL single_ack_hold: got %b want 1 after m+1", ack_out);
        end
        tick();  // edge m+2
        checks++;
        if (ack_out !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_fall: got %b want 0 after m+2", ack_out);
        end
        go_idle();
    endtask

    task automatic test_backpressure;
        int bad;
        data_in  = 8'hA5;
        rx_ready = 1'b0;
        req_in   = 1'b1;
        repeat (3) tick();
        data_in = 8'h3C;
        bad = 0;
        repeat (5) begin
            tick();
            if ({ack_out, rx_valid, rx_data} !== {1'b0, 1'b1, 8'hA5}) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d bad cycles want 0 (last ack/valid/data=%b/%b/%h)", bad, ack_out, rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        tick();
        checks++;
        if ({ack_out, rx_valid, rx_data} !== {1'b1, 1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL bp_release: got ack/valid/data=%b/%b/%h want 1/0/a5", ack_out, rx_valid, rx_data);
        end
        go_idle();
    endtask

    task automatic test_held_request;
        int pulses;
        int ack_cycles;
        int n;
        data_in  = 8'h77;
        rx_ready = 1'b1;
        req_in   = 1'b1;
        pulses   = 0;
        n        = 0;
        while (ack_out !== 1'b1 && n < 10) begin
            tick();
            n++;
            if (rx_valid === 1'b1) pulses++;
        end
        ack_cycles = 0;
        repeat (20) begin
            tick();
            if (rx_valid === 1'b1) pulses++;
            if (ack_out === 1'b1) ack_cycles++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL held_pulses: got %0d rx_valid cycles want 1", pulses);
        end
        checks++;
        if (ack_cycles !== 20) begin
            errors++;
            $display("FAIL held_ack: got %0d ack cycles want 20", ack_cycles);
        end
        go_idle();
    endtask

    logic [DATA_W-1:0] got_q[$];
    int                cyc;
    int                last_cap;
    int                min_gap;

    task automatic b2b_sample;
        tick();
        cyc++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            got_q.push_back(rx_data);
            if (last_cap >= 0 && (cyc - last_cap) < min_gap) min_gap = cyc - last_cap;
            last_cap = cyc;
        end
    endtask

    task automatic test_back_to_back;
        int n;
        got_q.delete();
        cyc      = 0;
        last_cap = -1;
        min_gap  = 1000;
        rx_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            data_in = 8'(w);
            req_in  = 1'b1;
            n = 0;
            while (ack_out !== 1'b1 && n < 20) begin
                b2b_sample();
                n++;
            end
            checks++;
            if (ack_out !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ack_rise_timeout: word %0d ack=%b want 1", w, ack_out);
            end
            req_in = 1'b0;
            n = 0;
            while (ack_out !== 1'b0 && n < 20) begin
                b2b_sample();
                n++;
            end
            checks++;
            if (ack_out !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ack_fall_timeout: word %0d ack=%b want 0", w, ack_out);
            end
        end
        repeat (4) b2b_sample();
        checks++;
        if (got_q.size() !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d words want 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (min_gap < 6) begin
            errors++;
            $display("FAIL b2b_gap: got min %0d clocks between captures want >= 6", min_gap);
        end
        go_idle();
    endtask

    task automatic test_reset_mid;
        data_in  = 8'hC3;
        rx_ready = 1'b0;
        req_in   = 1'b1;
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ack_out, rx_valid, rx_data} !== 10'h000) begin
            errors++;
            $display("FAIL reset_mid_hold: got ack/valid/data=%b/%b/%h want 0/0/00", ack_out, rx_valid, rx_data);
        end
        tick();
        reset_n = 1'b1;
        tick();  // r1
        tick();  // r2
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_early_capture: got valid=%b want 0 before req_sync high", rx_valid);
        end
        tick();  // r3
        checks++;
        if ({rx_valid, rx_data} !== {1'b1, 8'hC3}) begin
            errors++;
            $display("FAIL reset_mid_recapture: got valid/data=%b/%h want 1/c3", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ack_out, rx_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_ack: got ack/valid=%b/%b want 0/0", ack_out, rx_valid);
        end
        tick();
        req_in  = 1'b0;
        reset_n = 1'b1;
        go_idle();
    endtask

    task automatic test_violation;
        data_in  = 8'h5A;
        rx_ready = 1'b0;
        req_in   = 1'b1;
        repeat (3) tick();
        req_in = 1'b0;
        repeat (3) tick();
        checks++;
        if ({ack_out, rx_valid, rx_data} !== {1'b0, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL viol_hold: got ack/valid/data=%b/%b/%h want 0/1/5a", ack_out, rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        tick();
        checks++;
        if ({ack_out, rx_valid} !== 2'b10) begin
            errors++;
            $display("FAIL viol_ack_pulse: got ack/valid=%b/%b want 1/0", ack_out, rx_valid);
        end
        tick();
        checks++;
        if (ack_out !== 1'b0) begin
            errors++;
            $display("FAIL viol_ack_drop: got ack=%b want 0", ack_out);
        end
`ifdef HS4_RX_ERR_EN
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b want 1", err_o);
        end
        data_in = 8'h11;
        req_in  = 1'b1;
        repeat (5) tick();
        go_idle();
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", err_o);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b want 0", err_o);
        end
        tick();
        reset_n = 1'b1;
`endif
        go_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_held_request();
        test_back_to_back();
        test_reset_mid();
        test_violation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hs4_rx
